// File: rtl/param_slice_fifo.sv
// Field extractor feeding a DEPTH-entry FIFO: slices OUT_WIDTH bits from each accepted
// IN_WIDTH-bit word at a programmable offset and queues them on a valid/ready output stream.
module param_slice_fifo #(
  parameter int unsigned IN_WIDTH     = 8,
  parameter int unsigned OUT_WIDTH    = 2,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned RESET_OFFSET = 1,
  parameter int unsigned OFS_W        = ($clog2(IN_WIDTH + 1) > 1) ? $clog2(IN_WIDTH + 1) : 1,
  parameter int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_we,
  input  logic [OFS_W-1:0]     cfg_offset,
  output logic                 cfg_err,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]     count
);

  localparam int unsigned PTR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

  logic [OFS_W-1:0]     offset_q, offset_d;
  logic                 cfg_err_q, cfg_err_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [OUT_WIDTH-1:0] mem_q [DEPTH];

  logic                 push, pop, cfg_legal;
  logic [OUT_WIDTH-1:0] field;

  // Zero-extending before the shift makes bits above IN_WIDTH-1 read as 0 (no wrap).
  assign field = OUT_WIDTH'({{OUT_WIDTH{1'b0}}, in_data} >> offset_q);

  assign in_ready  = (count_q < CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign cfg_legal = (cfg_offset <= OFS_W'(IN_WIDTH - 1));

  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;
  assign cfg_err  = cfg_err_q;

  always_comb begin
    offset_d  = offset_q;
    cfg_err_d = cfg_err_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    if (cfg_we) begin
      if (cfg_legal) begin
        offset_d = cfg_offset;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    // Modulo-DEPTH wrap so non-power-of-two depths work.
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      offset_q  <= OFS_W'(RESET_OFFSET);
      cfg_err_q <= 1'b0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      offset_q  <= offset_d;
      cfg_err_q <= cfg_err_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // Storage needs no reset: out_data is masked while the FIFO is empty.
  always_ff @(posedge clock) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= field;
    end
  end

endmodule

// File: tb/tb_param_slice_fifo.sv
// Directed bench for param_slice_fifo: extraction, offset config, flow control, wrap and reset.
module tb_param_slice_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       cfg_we;
  logic [3:0] cfg_offset;
  logic       cfg_err;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_data;
  logic [2:0] count;

  int n_vec  = 0;
  int n_fail = 0;

  param_slice_fifo dut (
    .clock      (clock),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_offset (cfg_offset),
    .cfg_err    (cfg_err),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [1:0] exp);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_data"}, 32'(out_data), 32'(exp));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] ofs);
    cfg_we     = 1'b1;
    cfg_offset = ofs;
    step();
    cfg_we     = 1'b0;
  endtask

  logic [7:0] t5_din [6] = '{8'h03, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A};
  logic [1:0] t5_exp [6] = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11};

  initial begin
    reset = 1'b1; cfg_we = 1'b0; cfg_offset = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_data", 32'(out_data), 32'd0);
    check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);

    // 1: default offset 1, one-cycle latency
    push(8'h04);
    check_eq("t1_out_valid", 32'(out_valid), 32'd1);
    check_eq("t1_out_data", 32'(out_data), 32'b10);
    check_eq("t1_count", 32'(count), 32'd1);
    check_eq("t1_in_ready", 32'(in_ready), 32'd1);
    pop_chk("t1_pop", 2'b10);
    check_eq("t1_empty", 32'(count), 32'd0);

    // 2: fill, overflow attempt, drain
    push(8'h02); push(8'h04); push(8'h06); push(8'h00);
    check_eq("t2_full_count", 32'(count), 32'd4);
    check_eq("t2_full_in_ready", 32'(in_ready), 32'd0);
    push(8'hFF);
    check_eq("t2_no_overflow", 32'(count), 32'd4);
    pop_chk("t2_pop0", 2'b01);
    pop_chk("t2_pop1", 2'b10);
    pop_chk("t2_pop2", 2'b11);
    pop_chk("t2_pop3", 2'b00);
    check_eq("t2_drained_valid", 32'(out_valid), 32'd0);
    check_eq("t2_drained_data", 32'(out_data), 32'd0);

    // 3: push coinciding with offset write uses old offset; next push zero-fills bit 8
    cfg_we = 1'b1; cfg_offset = 4'd7; in_valid = 1'b1; in_data = 8'h04;
    step();
    cfg_we = 1'b0;
    push(8'h80);
    check_eq("t3_count", 32'(count), 32'd2);
    pop_chk("t3_old_ofs", 2'b10);
    pop_chk("t3_zero_fill", 2'b01);
    check_eq("t3_cfg_err", 32'(cfg_err), 32'd0);

    // 4: illegal offset is rejected and sticky
    cfg_write(4'd1);
    cfg_write(4'd9);
    check_eq("t4_err_set", 32'(cfg_err), 32'd1);
    push(8'h06);
    pop_chk("t4_ofs_kept", 2'b11);
    cfg_write(4'd0);
    check_eq("t4_err_sticky", 32'(cfg_err), 32'd1);
    push(8'h06);
    pop_chk("t4_ofs0", 2'b10);

    // 5: steady push+pop at count 2 wraps the pointers (offset 0)
    push(8'h01); push(8'h02);
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = t5_din[i]; out_ready = 1'b1;
      check_eq($sformatf("t5_data%0d", i), 32'(out_data), 32'(t5_exp[i]));
      check_eq($sformatf("t5_count%0d", i), 32'(count), 32'd2);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("t5_count_hold", 32'(count), 32'd2);
    push(8'h0B); push(8'h0C);
    check_eq("t5_full", 32'(count), 32'd4);
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    check_eq("t5_full_in_ready", 32'(in_ready), 32'd0);
    check_eq("t5_full_head", 32'(out_data), 32'b01);
    step();
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("t5_pop_only", 32'(count), 32'd3);
    pop_chk("t5_tail0", 2'b10);
    pop_chk("t5_tail1", 2'b11);
    pop_chk("t5_tail2", 2'b00);
    check_eq("t5_empty", 32'(out_valid), 32'd0);

    // 6: reset beats in-flight push, pop and cfg write
    cfg_write(4'd5);
    push(8'h20); push(8'h40); push(8'h60);
    check_eq("t6_pre_count", 32'(count), 32'd3);
    check_eq("t6_pre_head", 32'(out_data), 32'b01);
    reset = 1'b1; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    cfg_we = 1'b1; cfg_offset = 4'd3;
    step();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    check_eq("t6_count", 32'(count), 32'd0);
    check_eq("t6_out_valid", 32'(out_valid), 32'd0);
    check_eq("t6_out_data", 32'(out_data), 32'd0);
    check_eq("t6_in_ready", 32'(in_ready), 32'd1);
    check_eq("t6_cfg_err", 32'(cfg_err), 32'd0);
    push(8'h04);
    check_eq("t6_count_after", 32'(count), 32'd1);
    check_eq("t6_ofs_default", 32'(out_data), 32'b10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
